// File: rtl/msg_fifo_arbiter_pkg.sv
// Shared types and constants for the frame-end message FIFO arbiter.
package msg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam int MSG_WORDS_DEF = 3;

  // ASCII tags carried in word 0 of each producer's message
  localparam logic [31:0] MSG_ID_RBB = 32'h0052_4242;
  localparam logic [31:0] MSG_ID_GBB = 32'h0047_4242;
  localparam logic [31:0] MSG_ID_BBB = 32'h0042_4242;
  localparam logic [31:0] MSG_ID_STA = 32'h0053_5441;

endpackage

// File: rtl/msg_fifo_arbiter_if.sv
// Producer request bus plus MSG_FIFO write port, as seen by the arbiter.
interface msg_fifo_arbiter_if
  import msg_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MSG_WORDS = MSG_WORDS_DEF,
  parameter int USEDW_W   = 8
);

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MSG_WORDS*32-1:0] req_data;
  logic [NUM_REQ-1:0]              ack;
  logic [USEDW_W-1:0]              fifo_usedw;
  logic                            fifo_full;
  logic                            fifo_wrreq;
  logic [31:0]                     fifo_data;
  logic                            flush;
  logic                            busy;
  logic [2:0]                      grant_idx;
  logic [15:0]                     msg_count;

  modport master (
    input  req, req_data, fifo_usedw, fifo_full, flush,
    output ack, fifo_wrreq, fifo_data, busy, grant_idx, msg_count
  );

  modport slave (
    output req, req_data, fifo_usedw, fifo_full, flush,
    input  ack, fifo_wrreq, fifo_data, busy, grant_idx, msg_count
  );

endinterface

// File: rtl/msg_fifo_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic               valid_o,
  output logic [2:0]         winner_o
);

  logic [NUM_REQ-1:0] rot;

  // Rotate so that bit 0 is the producer at ptr
  assign rot = NUM_REQ'({req_i, req_i} >> ptr_i);

  always_comb begin
    int sum;
    valid_o  = 1'b0;
    winner_o = '0;
    sum      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!valid_o && rot[off]) begin
        valid_o = 1'b1;
        sum     = int'(ptr_i) + off;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end
        winner_o = 3'(sum);
      end
    end
  end

endmodule

// File: rtl/msg_fifo_arbiter.sv
// Grants one producer at a time and writes its message to MSG_FIFO as an
// atomic burst, only when the whole message fits.
module msg_fifo_arbiter
  import msg_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MSG_WORDS  = MSG_WORDS_DEF,
  parameter int FIFO_DEPTH = 256
) (
  input logic              clk,
  input logic              reset_n,
  msg_fifo_arbiter_if.master bus
);

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         widx_q, widx_d;
  logic [2:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               wrreq_q, wrreq_d;
  logic [31:0]        data_q, data_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        buf_q [MSG_WORDS];
  logic [31:0]        buf_d [MSG_WORDS];

  logic [31:0]        prod_words [NUM_REQ][MSG_WORDS];
  logic [31:0]        win_words  [MSG_WORDS];
  logic               arb_valid;
  logic [2:0]         winner;
  logic               space;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prod
      for (genvar gk = 0; gk < MSG_WORDS; gk++) begin : g_word
        assign prod_words[gi][gk] = bus.req_data[(gi*MSG_WORDS+gk)*32 +: 32];
      end
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (winner)
  );

  always_comb begin
    for (int k = 0; k < MSG_WORDS; k++) begin
      win_words[k] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) begin
        win_words = prod_words[i];
      end
    end
  end

  // Strict less-than leaves room for a full message before usedw catches up
  assign space = ~bus.fifo_full &
                 (32'(bus.fifo_usedw) < 32'(FIFO_DEPTH - MSG_WORDS));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    grant_d = grant_q;
    ack_d   = '0;
    wrreq_d = wrreq_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;

    if (bus.flush) begin
      state_d = IDLE;
      wrreq_d = 1'b0;
      widx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          wrreq_d = 1'b0;
          if (arb_valid && space) begin
            state_d = WRITE;
            grant_d = winner;
            ptr_d   = (winner == 3'(NUM_REQ-1)) ? 3'd0 : winner + 3'd1;
            widx_d  = '0;
            buf_d   = win_words;
            wrreq_d = 1'b1;
            data_d  = win_words[0];
            for (int i = 0; i < NUM_REQ; i++) begin
              ack_d[i] = (winner == 3'(i));
            end
          end
        end
        WRITE: begin
          if (widx_q == 3'(MSG_WORDS-1)) begin
            state_d = IDLE;
            wrreq_d = 1'b0;
            widx_d  = '0;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            // Buffer shifts down so the next word is always at index 1
            widx_d = widx_q + 3'd1;
            data_d = buf_q[1];
            for (int k = 0; k < MSG_WORDS-1; k++) begin
              buf_d[k] = buf_q[k+1];
            end
            buf_d[MSG_WORDS-1] = '0;
          end
        end
        default: begin
          state_d = IDLE;
          wrreq_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      widx_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < MSG_WORDS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.fifo_wrreq = wrreq_q;
  assign bus.fifo_data  = data_q;
  assign bus.busy       = wrreq_q;
  assign bus.grant_idx  = grant_q;
  assign bus.msg_count  = cnt_q;

endmodule

// File: tb/tb_msg_fifo_arbiter.sv
// Directed bench for msg_fifo_arbiter: one task per scenario, inline checks.
module tb_msg_fifo_arbiter;
  import msg_arb_pkg::*;

  localparam int NR = 4;
  localparam int MW = 3;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  msg_fifo_arbiter_if #(.NUM_REQ(NR), .MSG_WORDS(MW), .USEDW_W(8)) bus ();

  msg_fifo_arbiter #(.NUM_REQ(NR), .MSG_WORDS(MW), .FIFO_DEPTH(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input int p, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2);
    bus.req_data[(p*MW+0)*32 +: 32] = w0;
    bus.req_data[(p*MW+1)*32 +: 32] = w1;
    bus.req_data[(p*MW+2)*32 +: 32] = w2;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.req        = '0;
    bus.flush      = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fifo_usedw = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.ack !== 4'b0000 || bus.fifo_wrreq !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ack=%b wrreq=%b busy=%b, want 0000/0/0",
               bus.ack, bus.fifo_wrreq, bus.busy);
    end
    tests++;
    if (bus.fifo_data !== 32'h0 || bus.grant_idx !== 3'd0 || bus.msg_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_data: data=%h grant=%0d count=%0d, want 0/0/0",
               bus.fifo_data, bus.grant_idx, bus.msg_count);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    logic [31:0] exp_w [MW];
    exp_w[0] = MSG_ID_RBB;
    exp_w[1] = 32'h0020_0150;
    exp_w[2] = 32'h0000_0000;
    do_reset();
    set_words(1, exp_w[0], exp_w[1], exp_w[2]);
    bus.req = 4'b0010;
    tick();
    tests++;
    if (bus.ack !== 4'b0010 || bus.grant_idx !== 3'd1) begin
      fails++;
      $display("FAIL single_ack: ack=%b grant=%0d, want 0010/1", bus.ack, bus.grant_idx);
    end
    bus.req = 4'b0000;
    for (int k = 0; k < MW; k++) begin
      if (k > 0) tick();
      tests++;
      if (bus.fifo_wrreq !== 1'b1 || bus.busy !== 1'b1 || bus.fifo_data !== exp_w[k]) begin
        fails++;
        $display("FAIL single_word%0d: wrreq=%b busy=%b data=%h, want 1/1/%h",
                 k, bus.fifo_wrreq, bus.busy, bus.fifo_data, exp_w[k]);
      end
    end
    tick();
    tests++;
    if (bus.fifo_wrreq !== 1'b0 || bus.busy !== 1'b0 || bus.msg_count !== 16'd1) begin
      fails++;
      $display("FAIL single_end: wrreq=%b busy=%b count=%0d, want 0/0/1",
               bus.fifo_wrreq, bus.busy, bus.msg_count);
    end
    $display("[TB] test_single done: producer 1 message written");
  endtask

  task automatic test_contention();
    do_reset();
    set_words(0, 32'h0000_0A00, 32'h0000_0A01, 32'h0000_0A02);
    set_words(2, 32'h0000_0C00, 32'h0000_0C01, 32'h0000_0C02);
    set_words(3, 32'h0000_0D00, 32'h0000_0D01, 32'h0000_0D02);
    bus.req = 4'b0101;
    tick();
    tests++;
    if (bus.ack !== 4'b0001 || bus.fifo_data !== 32'h0000_0A00) begin
      fails++;
      $display("FAIL contention_first: ack=%b data=%h, want 0001/00000a00", bus.ack, bus.fifo_data);
    end
    bus.req = 4'b0100;
    for (int c = 1; c < 4; c++) begin
      tick();
      tests++;
      if (bus.ack !== 4'b0000) begin
        fails++;
        $display("FAIL contention_gap%0d: ack=%b, want 0000", c, bus.ack);
      end
    end
    tick();
    tests++;
    if (bus.ack !== 4'b0100 || bus.grant_idx !== 3'd2 || bus.fifo_data !== 32'h0000_0C00) begin
      fails++;
      $display("FAIL contention_second: ack=%b grant=%0d data=%h, want 0100/2/00000c00",
               bus.ack, bus.grant_idx, bus.fifo_data);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    bus.req = 4'b1001;
    tick();
    tests++;
    if (bus.ack !== 4'b1000 || bus.grant_idx !== 3'd3) begin
      fails++;
      $display("FAIL contention_ptr: ack=%b grant=%0d, want 1000/3", bus.ack, bus.grant_idx);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    tests++;
    if (bus.msg_count !== 16'd3) begin
      fails++;
      $display("FAIL contention_count: count=%0d, want 3", bus.msg_count);
    end
    $display("[TB] test_contention done: grants 0,2,3");
  endtask

  task automatic test_space_limit();
    do_reset();
    set_words(0, 32'h1111_0000, 32'h1111_0001, 32'h1111_0002);
    set_words(1, 32'h2222_0000, 32'h2222_0001, 32'h2222_0002);
    bus.fifo_usedw = 8'd253;
    bus.req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (bus.ack !== 4'b0000 || bus.fifo_wrreq !== 1'b0) begin
        fails++;
        $display("FAIL space_253_c%0d: ack=%b wrreq=%b, want 0000/0", c, bus.ack, bus.fifo_wrreq);
      end
    end
    bus.fifo_usedw = 8'd252;
    tick();
    tests++;
    if (bus.ack !== 4'b0001 || bus.fifo_data !== 32'h1111_0000) begin
      fails++;
      $display("FAIL space_252: ack=%b data=%h, want 0001/11110000", bus.ack, bus.fifo_data);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    bus.fifo_usedw = 8'd0;
    bus.fifo_full  = 1'b1;
    bus.req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (bus.ack !== 4'b0000 || bus.fifo_wrreq !== 1'b0) begin
        fails++;
        $display("FAIL space_full_c%0d: ack=%b wrreq=%b, want 0000/0", c, bus.ack, bus.fifo_wrreq);
      end
    end
    bus.fifo_full = 1'b0;
    tick();
    tests++;
    if (bus.ack !== 4'b0010 || bus.grant_idx !== 3'd1) begin
      fails++;
      $display("FAIL space_release: ack=%b grant=%0d, want 0010/1", bus.ack, bus.grant_idx);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    $display("[TB] test_space_limit done");
  endtask

  task automatic test_flush();
    do_reset();
    set_words(0, 32'h3333_0000, 32'h3333_0001, 32'h3333_0002);
    set_words(1, 32'h4444_0000, 32'h4444_0001, 32'h4444_0002);
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0010;
    tick();
    tests++;
    if (bus.fifo_wrreq !== 1'b1 || bus.fifo_data !== 32'h3333_0001) begin
      fails++;
      $display("FAIL flush_word1: wrreq=%b data=%h, want 1/33330001", bus.fifo_wrreq, bus.fifo_data);
    end
    bus.flush = 1'b1;
    tick();
    tests++;
    if (bus.fifo_wrreq !== 1'b0 || bus.busy !== 1'b0 || bus.msg_count !== 16'd0) begin
      fails++;
      $display("FAIL flush_abort: wrreq=%b busy=%b count=%0d, want 0/0/0",
               bus.fifo_wrreq, bus.busy, bus.msg_count);
    end
    tick();
    tests++;
    if (bus.ack !== 4'b0000 || bus.fifo_wrreq !== 1'b0) begin
      fails++;
      $display("FAIL flush_blocks_grant: ack=%b wrreq=%b, want 0000/0", bus.ack, bus.fifo_wrreq);
    end
    bus.flush = 1'b0;
    tick();
    tests++;
    if (bus.ack !== 4'b0010 || bus.fifo_data !== 32'h4444_0000) begin
      fails++;
      $display("FAIL flush_regrant: ack=%b data=%h, want 0010/44440000", bus.ack, bus.fifo_data);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    tests++;
    if (bus.msg_count !== 16'd1) begin
      fails++;
      $display("FAIL flush_count: count=%0d, want 1", bus.msg_count);
    end
    $display("[TB] test_flush done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_words(2, 32'h5555_0000, 32'h5555_0001, 32'h5555_0002);
    set_words(3, 32'h6666_0000, 32'h6666_0001, 32'h6666_0002);
    bus.req = 4'b0100;
    tick();
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b0000;
    tick();
    tests++;
    if (bus.msg_count !== 16'd1 || bus.grant_idx !== 3'd3 || bus.fifo_wrreq !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: count=%0d grant=%0d wrreq=%b, want 1/3/1",
               bus.msg_count, bus.grant_idx, bus.fifo_wrreq);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tests++;
    if (bus.fifo_wrreq !== 1'b0 || bus.busy !== 1'b0 || bus.fifo_data !== 32'h0 ||
        bus.grant_idx !== 3'd0 || bus.msg_count !== 16'd0 || bus.ack !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_values: wrreq=%b busy=%b data=%h grant=%0d count=%0d ack=%b, want all 0",
               bus.fifo_wrreq, bus.busy, bus.fifo_data, bus.grant_idx, bus.msg_count, bus.ack);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (bus.fifo_wrreq !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_quiet%0d: wrreq=%b, want 0", c, bus.fifo_wrreq);
      end
    end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_starvation();
    logic [31:0] ids [NR];
    logic [3:0]  exp_ack;
    bit          got;
    ids[0] = MSG_ID_RBB;
    ids[1] = MSG_ID_GBB;
    ids[2] = MSG_ID_BBB;
    ids[3] = MSG_ID_STA;
    do_reset();
    for (int p = 0; p < NR; p++) begin
      set_words(p, ids[p], 32'(p), 32'hFFFF_0000 | 32'(p));
    end
    bus.req = 4'b1111;
    for (int n = 0; n < 16; n++) begin
      exp_ack = 4'b0001 << (n % NR);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        if (bus.ack !== 4'b0000) got = 1'b1;
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL starve_timeout msg%0d: ack=%b, want %b within 10 cycles", n, bus.ack, exp_ack);
      end else if (bus.ack !== exp_ack || bus.grant_idx !== 3'(n % NR) ||
                   bus.fifo_data !== ids[n % NR]) begin
        fails++;
        $display("FAIL starve_order msg%0d: ack=%b grant=%0d data=%h, want %b/%0d/%h",
                 n, bus.ack, bus.grant_idx, bus.fifo_data, exp_ack, n % NR, ids[n % NR]);
      end
      bus.req = bus.req & ~exp_ack;
      tick();
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tests++;
    if (bus.msg_count !== 16'd16) begin
      fails++;
      $display("FAIL starve_count: count=%0d, want 16", bus.msg_count);
    end
    $display("[TB] test_starvation done: 16 messages");
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    bus.req        = '0;
    bus.req_data   = '0;
    bus.flush      = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fifo_usedw = '0;
    test_reset();
    test_single();
    test_contention();
    test_space_limit();
    test_flush();
    test_reset_mid();
    test_starvation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msg_fifo_arbiter.md
# msg_fifo_arbiter

Shares the single 32-bit CPU message FIFO between several frame-end message producers (red/green/blue bounding-box detectors, statistics units). Each producer requests once per frame with a complete fixed-length message. The block grants one producer at a time in round-robin order, writes its message to the FIFO as an atomic burst, and starts a burst only when the whole message fits. It sits between the detector units and the MSG_FIFO write port in the image-processing IP; the Avalon-MM read/flush path is unchanged.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- MSG_WORDS, 3, words per message (2..8)
- FIFO_DEPTH, 256, FIFO capacity in words
- USEDW_W, 8, width of FIFO used-words count
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- req  in  NUM_REQ  per-producer request level
- req_data  in  NUM_REQ*MSG_WORDS*32  producer i word k at bits [(i*MSG_WORDS+k)*32 +: 32]
- ack  out  NUM_REQ  one-cycle pulse: message of producer i captured
- fifo_usedw  in  USEDW_W  FIFO fill level
- fifo_full  in  1  FIFO full flag
- fifo_wrreq  out  1  FIFO write strobe
- fifo_data  out  32  FIFO write word
- flush  in  1  FIFO clear request, same signal that drives FIFO sclr
- busy  out  1  burst in progress
- grant_idx  out  3  index of the current or last granted producer
- msg_count  out  16  number of completed messages, wraps

## Operation
- States: IDLE, WRITE. Word counter widx is 0..MSG_WORDS-1.
- Space condition: ~fifo_full & (fifo_usedw < FIFO_DEPTH - MSG_WORDS).
- IDLE with any req and space true:
  - Pick the winner round-robin, searching upward from ptr with wrap.
  - Capture the winner's MSG_WORDS words into an internal buffer.
  - Register ack[winner] = 1 and grant_idx = winner.
  - Set ptr = (winner+1) mod NUM_REQ. Go to WRITE with widx = 0.
- IDLE with space false: no grant. Requests stay pending; producers hold req and data.
- WRITE: fifo_wrreq = 1, fifo_data = buf[widx], widx increments.
  - After widx = MSG_WORDS-1: msg_count += 1, go to IDLE.
- Producers must drop req on the cycle after they see ack. Data needs to be stable only in the grant cycle.
- flush (any state): go to IDLE, fifo_wrreq = 0, clear widx, no msg_count increment. ptr is kept. A burst aborted this way is lost, which matches the FIFO clear.
- flush and a grant in the same cycle: flush wins. No ack, no capture.
- Reset: state IDLE, ptr = 0, widx = 0, ack = 0, fifo_wrreq = 0, fifo_data = 0, busy = 0, grant_idx = 0, msg_count = 0, buffer = 0.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle t with space true:
  - ack at t+1.
  - Words 0..MSG_WORDS-1 written at cycles t+1..t+MSG_WORDS.
  - IDLE again at t+MSG_WORDS+1.
- At least one IDLE cycle separates bursts, so fifo_usedw reflects the previous burst before the next space check.
- Peak throughput: one message per MSG_WORDS+1 cycles.
- busy is high exactly during the fifo_wrreq cycles.
- msg_count updates the cycle after the last word is written.
- A mid-burst reset or flush takes effect at the next edge. fifo_wrreq is low from the following cycle.

## Structure
- Package msg_arb_pkg holds:
  - state enum {IDLE, WRITE}
  - MSG_WORDS default
  - message ID constants: "RBB", "GBB", "BBB", "STA"
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req, ptr
  - outputs: valid, winner index (combinational)
- All sequencing stays in msg_fifo_arbiter.

## Test plan
- Single request: req[1]=1 with words {"RBB", 0x00200150, 0}, usedw=0 -> ack[1] at t+1; fifo_wrreq high 3 cycles with exactly those words in order; msg_count=1.
- Contention: req[0] and req[2] high together with ptr=0 -> producer 0 served first, producer 2 next; producer 2's ack arrives 4 cycles after producer 0's; ptr ends at 3.
- Space limit: usedw=253 (256-3) -> no ack while requests are held; at usedw=252 -> grant on the next IDLE cycle. fifo_full=1 with usedw=0 -> no grant.
- Flush mid-burst: flush on the 2nd write cycle -> fifo_wrreq low next cycle; msg_count unchanged; state IDLE; a pending req is granted the cycle after flush deasserts.
- Reset mid-burst: reset_n low during word 1 -> all outputs at reset values next cycle; no further writes.
- Starvation: all 4 producers requesting continuously, re-raising req after each ack -> grant order 0,1,2,3,0,... with no producer skipped over 16 messages.
